// File: rtl/link_readline_arb_pkg.sv
// Shared definitions for the multi-channel readline link stages:
// arbiter state encoding and a grant-index width helper.
package link_readline_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } LinkState;

  // Keeps index ports at least one bit wide when only one channel exists.
  function automatic int idxWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/link_readline_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping modulo N.
module link_rr_pick
  import link_readline_arb_pkg::*;
#(
  parameter int  N  = 2,
  localparam int IW = idxWidth(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  // Scan from the far end back toward the pointer so the closest request wins.
  always_comb begin
    logic [IW-1:0] w_cand;
    w_cand  = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = IW'((int'(i_ptr) + k) % N);
      if (i_req[w_cand]) begin
        o_idx   = w_cand;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/link_readline_arb.sv
// Round-robin arbiter joining several readline requesters onto one shared
// responder; requests are latched so a requester may drop its strobe early.
module link_readline_arb
  import link_readline_arb_pkg::*;
#(
  parameter int  CHANNELS = 2,
  parameter int  ADDR_W   = 32,
  parameter int  LINE_W   = 128,
  localparam int IDX_W    = idxWidth(CHANNELS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          req_readline_do,
  output logic [CHANNELS-1:0]          req_readline_done,
  input  logic [CHANNELS*ADDR_W-1:0]   req_readline_address,
  output logic [LINE_W-1:0]            req_readline_line,
  output logic                         resp_readline_do,
  input  logic                         resp_readline_done,
  output logic [ADDR_W-1:0]            resp_readline_address,
  input  logic [LINE_W-1:0]            resp_readline_line,
  output logic [IDX_W-1:0]             grant_idx
);

  LinkState            r_state;
  LinkState            w_nextState;
  logic [CHANNELS-1:0] w_effDo;
  logic [CHANNELS-1:0] w_owned;
  logic [ADDR_W-1:0]   w_effAddr [CHANNELS];
  logic [IDX_W-1:0]    r_grant;
  logic [IDX_W-1:0]    r_rrPtr;
  logic [IDX_W-1:0]    w_winIdx;
  logic                w_winValid;
  logic [ADDR_W-1:0]   r_capAddr;
  logic                w_fire;

  function automatic logic [IDX_W-1:0] nextPtr(input logic [IDX_W-1:0] idx);
    return (int'(idx) >= CHANNELS - 1) ? '0 : idx + IDX_W'(1);
  endfunction

  // A channel only latches while it does not already own the responder.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic              r_pending;
    logic [ADDR_W-1:0] r_addrQ;

    assign w_owned[gi] = (r_state == BUSY && r_grant == IDX_W'(gi)) ||
                         (r_state == IDLE && w_winValid && w_winIdx == IDX_W'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        r_pending <= 1'b0;
        r_addrQ   <= '0;
      end else if (req_readline_done[gi]) begin
        r_pending <= 1'b0;
      end else if (req_readline_do[gi] && !w_owned[gi]) begin
        r_pending <= 1'b1;
        r_addrQ   <= req_readline_address[gi*ADDR_W +: ADDR_W];
      end
    end

    assign w_effDo[gi]   = req_readline_do[gi] | r_pending;
    assign w_effAddr[gi] = req_readline_do[gi] ? req_readline_address[gi*ADDR_W +: ADDR_W]
                                               : r_addrQ;
  end

  link_rr_pick #(.N(CHANNELS)) u_pick (
    .i_req   (w_effDo),
    .i_ptr   (r_rrPtr),
    .o_idx   (w_winIdx),
    .o_valid (w_winValid)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_winValid && !resp_readline_done) w_nextState = BUSY;
      BUSY:    if (resp_readline_done) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // IDLE grants drive the responder combinationally so a request costs no extra cycle.
  always_comb begin
    resp_readline_do      = 1'b0;
    resp_readline_address = r_capAddr;
    req_readline_done     = '0;
    grant_idx             = r_grant;
    w_fire                = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_winValid) begin
          resp_readline_do      = 1'b1;
          resp_readline_address = w_effAddr[w_winIdx];
          grant_idx             = w_winIdx;
          if (resp_readline_done) begin
            req_readline_done[w_winIdx] = 1'b1;
            w_fire                      = 1'b1;
          end
        end
      end
      BUSY: begin
        resp_readline_do = 1'b1;
        if (resp_readline_done) begin
          req_readline_done[r_grant] = 1'b1;
          w_fire                     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant   <= '0;
      r_capAddr <= '0;
      r_rrPtr   <= '0;
    end else begin
      if (r_state == IDLE && w_winValid) begin
        r_grant   <= w_winIdx;
        r_capAddr <= w_effAddr[w_winIdx];
      end
      if (w_fire) r_rrPtr <= nextPtr(grant_idx);
    end
  end

  assign req_readline_line = resp_readline_line;

endmodule

// File: tb/tb_link_readline_arb.sv
// Scoreboard bench for link_readline_arb with four channels and a
// latency-programmable responder model.
module tb_link_readline_arb;

  localparam int CH = 4;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int IW = 2;

  typedef struct {
    int          ch;
    logic [AW-1:0] addr;
  } Txn;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     reqDo;
  logic [CH-1:0]     reqDone;
  logic [CH*AW-1:0]  reqAddr;
  logic [LW-1:0]     reqLine;
  logic              respDo;
  logic              respDone;
  logic [AW-1:0]     respAddr;
  logic [LW-1:0]     respLine;
  logic [IW-1:0]     grantIdx;

  Txn            expQ[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            respLatency = 1;
  bit            respAuto = 1'b1;
  logic          manualDone = 1'b0;
  logic [LW-1:0] manualLine = '0;
  int            respDoCycles = 0;
  logic [CH-1:0] expVec;

  always #5 clk = ~clk;

  link_readline_arb #(.CHANNELS(CH), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .req_readline_do       (reqDo),
    .req_readline_done     (reqDone),
    .req_readline_address  (reqAddr),
    .req_readline_line     (reqLine),
    .resp_readline_do      (respDo),
    .resp_readline_done    (respDone),
    .resp_readline_address (respAddr),
    .resp_readline_line    (respLine),
    .grant_idx             (grantIdx)
  );

  function automatic logic [LW-1:0] lineOf(input logic [AW-1:0] a);
    return {4{a ^ 32'hA5A5_A5A5}};
  endfunction

  task automatic checkOutput(input string tag, input logic [LW-1:0] observed,
                             input logic [LW-1:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic setAddr(input int ch, input logic [AW-1:0] a);
    reqAddr[ch*AW +: AW] = a;
  endtask

  task automatic expectTxn(input int ch, input logic [AW-1:0] a);
    Txn t;
    t.ch   = ch;
    t.addr = a;
    expQ.push_back(t);
  endtask

  // Raise the given strobes for a number of cycles, then drop them.
  task automatic applyStimulus(input logic [CH-1:0] mask, input int cycles);
    @(posedge clk); #1;
    reqDo = mask;
    repeat (cycles) @(posedge clk);
    #1 reqDo = '0;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic resetDut();
    rst   = 1'b1;
    reqDo = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      @(posedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      checkOutput("drain_timeout", expQ.size(), 0);
      expQ.delete();
    end
    #1;
  endtask

  // Responder model: counts resp_do cycles and answers after respLatency of them.
  initial begin : responder
    int  cnt;
    bit  doneNext;
    cnt      = 0;
    doneNext = 1'b0;
    respDone = 1'b0;
    respLine = '0;
    forever begin
      @(negedge clk);
      if (respAuto && respDo && !respDone) begin
        cnt++;
        if (cnt >= respLatency) begin
          doneNext = 1'b1;
          cnt      = 0;
        end
      end else if (!respAuto || !respDo) begin
        cnt      = 0;
        doneNext = 1'b0;
      end
      @(posedge clk); #1;
      if (respAuto) begin
        respDone = doneNext;
        if (doneNext) respLine = lineOf(respAddr);
      end else begin
        respDone = manualDone;
        respLine = manualLine;
      end
      doneNext = 1'b0;
    end
  end

  // Scoreboard: every completion must match the oldest expected transaction.
  always @(negedge clk) begin
    Txn e;
    if (respDo) respDoCycles++;
    if (reqDone != '0) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", reqDone, 0);
      end else begin
        e = expQ.pop_front();
        expVec = '0;
        expVec[e.ch] = 1'b1;
        checkOutput("done_vec", reqDone, expVec);
        checkOutput("done_addr", respAddr, e.addr);
        checkOutput("done_grant", grantIdx, e.ch);
        checkOutput("done_line", reqLine, lineOf(e.addr));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    rst     = 1'b1;
    reqDo   = '0;
    reqAddr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_resp_do", respDo, 0);
    checkOutput("rst_req_done", reqDone, 0);
    checkOutput("rst_resp_addr", respAddr, 0);
    checkOutput("rst_grant", grantIdx, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single one-cycle pulse on ch0, answered on the fourth resp_do cycle.
    respLatency  = 3;
    respDoCycles = 0;
    setAddr(0, 32'h0000_1000);
    expectTxn(0, 32'h0000_1000);
    applyStimulus(4'b0001, 1);
    waitDrain(50);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("pulse_do_cycles", respDoCycles, 4);

    // Simultaneous ch0/ch1 requests: ch0 first, ch1 from its latch.
    resetDut();
    respLatency = 1;
    setAddr(0, 32'h100);
    setAddr(1, 32'h200);
    expectTxn(0, 32'h100);
    expectTxn(1, 32'h200);
    applyStimulus(4'b0011, 1);
    waitDrain(50);

    // Fairness: all channels request continuously.
    resetDut();
    respLatency = 1;
    for (int c = 0; c < CH; c++) setAddr(c, 32'h5000 + 32'(c) * 32'h10);
    expectTxn(0, 32'h5000);
    expectTxn(1, 32'h5010);
    expectTxn(2, 32'h5020);
    expectTxn(3, 32'h5030);
    expectTxn(0, 32'h5000);
    expectTxn(1, 32'h5010);
    reqDo = 4'b1111;
    waitDrain(100);
    resetDut();

    // Address captured at grant stays put while the requester changes it.
    respLatency = 3;
    setAddr(1, 32'h300);
    expectTxn(1, 32'h300);
    applyStimulus(4'b0010, 1);
    setAddr(1, 32'h400);
    @(negedge clk);
    checkOutput("stable_addr", respAddr, 32'h300);
    checkOutput("stable_grant", grantIdx, 1);
    waitDrain(50);

    // Zero-latency completion in the granting IDLE cycle.
    resetDut();
    respAuto = 1'b0;
    setAddr(2, 32'h700);
    expectTxn(2, 32'h700);
    @(negedge clk);
    manualDone = 1'b1;
    manualLine = lineOf(32'h700);
    @(posedge clk); #1;
    reqDo = 4'b0100;
    @(negedge clk);
    manualDone = 1'b0;
    @(posedge clk); #1;
    reqDo = '0;
    @(negedge clk);
    checkOutput("zl_no_busy", respDo, 0);
    checkOutput("zl_drained", expQ.size(), 0);

    // Pointer now sits after ch2, so ch3 beats ch1.
    respAuto    = 1'b1;
    respLatency = 1;
    @(posedge clk); #1;
    setAddr(3, 32'hB00);
    setAddr(1, 32'h900);
    expectTxn(3, 32'hB00);
    expectTxn(1, 32'h900);
    applyStimulus(4'b1010, 1);
    waitDrain(50);

    // Reset in the middle of a transaction abandons it.
    respLatency = 5;
    setAddr(2, 32'hC00);
    applyStimulus(4'b0100, 1);
    @(negedge clk);
    checkOutput("mid_grant", grantIdx, 2);
    @(posedge clk); #1;
    respAuto   = 1'b0;
    manualDone = 1'b0;
    rst        = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_do", respDo, 0);
    checkOutput("mid_rst_grant", grantIdx, 0);
    checkOutput("mid_rst_done", reqDone, 0);
    manualDone = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("stray_done", reqDone, 0);
    checkOutput("stray_do", respDo, 0);
    manualDone = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("post_rst_idle", respDo, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
